// File: rtl/branch_redirect_controller_if.sv
// EX-to-fetch redirect bus: branch decision and stall inputs, PC mux/flush controls and perf counters out.
interface branch_redirect_controller_if #(parameter int CNT_W = 16);
  logic             BRANCH_SEL;
  logic [31:0]      B_PC;
  logic             EX_VALID;
  logic             PIPE_STALL;
  logic             IF_STALL;
  logic             PC_SEL;
  logic [31:0]      PC_TARGET;
  logic             FLUSH_IF_ID;
  logic             FLUSH_ID_EX;
  logic             REDIRECT_BUSY;
  logic             MISALIGN;
  logic [CNT_W-1:0] TAKEN_COUNT;
  logic [CNT_W-1:0] FLUSH_COUNT;

  modport master (
    output BRANCH_SEL, B_PC, EX_VALID, PIPE_STALL, IF_STALL,
    input  PC_SEL, PC_TARGET, FLUSH_IF_ID, FLUSH_ID_EX, REDIRECT_BUSY,
           MISALIGN, TAKEN_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  BRANCH_SEL, B_PC, EX_VALID, PIPE_STALL, IF_STALL,
    output PC_SEL, PC_TARGET, FLUSH_IF_ID, FLUSH_ID_EX, REDIRECT_BUSY,
           MISALIGN, TAKEN_COUNT, FLUSH_COUNT
  );
endinterface

// File: rtl/branch_redirect_controller.sv
// Sequences PC redirect and wrong-path squash for EX-resolved branches, holding the
// redirect while fetch is stalled; keeps redirect/flush performance counters.
module branch_redirect_controller #(
  parameter int CNT_W = 16
) (
  input  logic CLK,
  input  logic RESET,
  branch_redirect_controller_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_IF = 1'b1} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_hold;
  logic [CNT_W-1:0] r_taken, r_flush;
  logic             r_misalign;

  logic             w_take;
  logic             w_pc_sel, w_flush, w_busy, w_capture;
  logic [31:0]      w_target;

  // A stalled EX stage keeps the branch in place; it is taken once the stall releases.
  assign w_take = bus.BRANCH_SEL & bus.EX_VALID & ~bus.PIPE_STALL;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_take && bus.IF_STALL) w_next = ST_WAIT_IF;
      ST_WAIT_IF: if (!bus.IF_STALL)          w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Control outputs are gated by RESET so nothing leaks while reset is held.
  always_comb begin
    w_pc_sel  = 1'b0;
    w_flush   = 1'b0;
    w_busy    = 1'b0;
    w_capture = 1'b0;
    w_target  = bus.B_PC;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_flush   = 1'b1;
          w_pc_sel  = ~bus.IF_STALL;
          w_capture = bus.IF_STALL;
        end
      end
      ST_WAIT_IF: begin
        w_busy   = 1'b1;
        w_flush  = 1'b1;
        w_target = r_hold;
        w_pc_sel = ~bus.IF_STALL;
      end
      default: ;
    endcase
    w_pc_sel  = w_pc_sel  & RESET;
    w_flush   = w_flush   & RESET;
    w_busy    = w_busy    & RESET;
    w_capture = w_capture & RESET;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hold     <= 32'h0;
      r_taken    <= '0;
      r_flush    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_capture) r_hold <= bus.B_PC;
      if (w_pc_sel)  r_taken <= r_taken + 1'b1;
      if (w_flush)   r_flush <= r_flush + 1'b1;
      r_misalign <= w_pc_sel & (|w_target[1:0]);
    end
  end

  assign bus.PC_SEL        = w_pc_sel;
  assign bus.PC_TARGET     = w_target;
  assign bus.FLUSH_IF_ID   = w_flush;
  assign bus.FLUSH_ID_EX   = w_flush;
  assign bus.REDIRECT_BUSY = w_busy;
  assign bus.MISALIGN      = r_misalign;
  assign bus.TAKEN_COUNT   = r_taken;
  assign bus.FLUSH_COUNT   = r_flush;

endmodule
